quad_decoder_counter: RTL



---
 rtl/quad_decoder_counter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/quad_decoder_counter.sv
// x4 quadrature decoder driving a loadable modulo-2^BITS up/down position counter.
// Optional per-phase glitch filter enabled by defining QUAD_GLITCH_FILTER_EN.
module quad_decoder_counter #(
    parameter int unsigned BITS        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            enable,
    input  logic            load,
    input  logic [BITS-1:0] D,
    output logic [BITS-1:0] Q,
    output logic            dir,
    output logic            step,
    output logic            err
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter
        $error("FILTER_LEN must be in 2..15");
    end

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int unsigned INIT_WAIT = SYNC_STAGES + FILTER_LEN;
`else
    localparam int unsigned INIT_WAIT = SYNC_STAGES;
`endif
    localparam int unsigned INIT_W = $clog2(INIT_WAIT + 1);

    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic [1:0]             raw_s;
    logic [1:0]             ph_s;

    // Input synchronizers, one chain per phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
        end
    end

    assign raw_s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]             filt_q, filt_d;
    logic [1:0][FCNT_W-1:0] fcnt_q, fcnt_d;

    // Filtered bit flips after FILTER_LEN consecutive samples that disagree with it
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (raw_s[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d[i] = raw_s[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign ph_s = filt_q;
`else
    assign ph_s = raw_s;
`endif

    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    logic [1:0]        prev_q, prev_d;
    logic              init_q, init_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [BITS-1:0]   q_q, q_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              err_q, err_d;
    logic [1:0]        delta;
    logic              step_c, up_c, err_c;

    // Gray-coded phase as position 0..3: +1 is a forward step, +3 reverse, +2 illegal jump
    always_comb begin
        delta  = 2'(gray2bin(ph_s) - gray2bin(prev_q));
        up_c   = (delta == 2'd1);
        step_c = init_q && ((delta == 2'd1) || (delta == 2'd3));
        err_c  = init_q && (delta == 2'd2);
    end

    // Reference phase is captured only once the sync (and filter) pipeline holds real samples
    always_comb begin
        prev_d     = prev_q;
        init_d     = init_q;
        init_cnt_d = init_cnt_q;
        q_d        = q_q;
        dir_d      = dir_q;
        step_d     = step_c;
        err_d      = err_c;

        if (!init_q) begin
            if (init_cnt_q == INIT_W'(INIT_WAIT)) begin
                prev_d = ph_s;
                init_d = 1'b1;
            end else begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
            end
        end else begin
            prev_d = ph_s;
        end

        if (step_c) begin
            dir_d = up_c;
        end

        if (load) begin
            q_d = D;
        end else if (enable && step_c) begin
            q_d = up_c ? q_q + BITS'(1) : q_q - BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            init_q     <= 1'b0;
            init_cnt_q <= '0;
            q_q        <= '0;
            dir_q      <= 1'b1;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            init_q     <= init_d;
            init_cnt_q <= init_cnt_d;
            q_q        <= q_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign Q    = q_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign err  = err_q;

endmodule
